// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter and its read-side demux.
// Holds the state encoding and the width derivations used by both sides.
package fifo_write_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arbState_e;

  function automatic int srcWidth(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

  // MAX_BURST of 0 means unlimited; keep a 1-bit counter so the port widths stay legal.
  function automatic int cntWidth(input int maxBurst);
    return (maxBurst > 0) ? $clog2(maxBurst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of validIn at or after baseIn,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int SRC_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   validIn,
  input  logic [SRC_WIDTH-1:0] baseIn,
  output logic [SRC_WIDTH-1:0] winnerOut,
  output logic                 anyValidOut
);

  // Scan from the farthest offset back to the base so the nearest valid wins last.
  always_comb begin
    int idx;
    idx         = 0;
    winnerOut   = '0;
    anyValidOut = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(baseIn) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (validIn[idx]) begin
        winnerOut   = SRC_WIDTH'(idx);
        anyValidOut = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-granular round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
//   state | meaning
//   IDLE  | no grant; pick next requester from ptrR onward
//   BURST | grantR owns the write port until a closing beat is accepted
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 16,
  localparam int SRC_WIDTH  = srcWidth(NUM_REQ),
  localparam int CNT_WIDTH  = cntWidth(MAX_BURST)
) (
  input  logic                          clkIn,
  input  logic                          rstNIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
  input  logic [NUM_REQ-1:0]            reqValidIn,
  input  logic [NUM_REQ-1:0]            reqLastIn,
  output logic [NUM_REQ-1:0]            reqReadyOut,
  output logic [DATA_WIDTH-1:0]         fifoDataOut,
  output logic                          fifoValidOut,
  input  logic                          fifoReadyIn,
  output logic [SRC_WIDTH-1:0]          fifoSrcOut,
  output logic                          fifoLastOut
);

  localparam logic [SRC_WIDTH-1:0] LAST_IDX  = SRC_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] FORCE_CNT = CNT_WIDTH'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  arbState_e             stateR, stateNext;
  logic [SRC_WIDTH-1:0]  grantR, grantNext;
  logic [SRC_WIDTH-1:0]  ptrR, ptrNext;
  logic [SRC_WIDTH-1:0]  winner;
  logic [CNT_WIDTH-1:0]  beatCntR, beatCntNext;
  logic                  anyValid;
  logic                  slotFree;
  logic                  accept;
  logic                  forcedLast;
  logic                  beatLast;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .SRC_WIDTH(SRC_WIDTH)
  ) uPick (
    .validIn    (reqValidIn),
    .baseIn     (ptrR),
    .winnerOut  (winner),
    .anyValidOut(anyValid)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign slotFree   = !fifoValidOut || fifoReadyIn;
  assign accept     = (stateR == BURST) && reqValidIn[grantR] && slotFree;
  assign forcedLast = (MAX_BURST > 0) && (beatCntR == FORCE_CNT);
  assign beatLast   = reqLastIn[grantR] || forcedLast;

  always_comb begin
    reqReadyOut = '0;
    if (stateR == BURST) reqReadyOut[grantR] = slotFree;
  end

  always_comb begin
    stateNext   = stateR;
    grantNext   = grantR;
    ptrNext     = ptrR;
    beatCntNext = beatCntR;
    case (stateR)
      IDLE: begin
        if (anyValid) begin
          grantNext   = winner;
          beatCntNext = '0;
          stateNext   = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          beatCntNext = beatCntR + 1'b1;
          if (beatLast) begin
            stateNext = IDLE;
            ptrNext   = (grantR == LAST_IDX) ? '0 : grantR + 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      stateR   <= IDLE;
      grantR   <= '0;
      ptrR     <= '0;
      beatCntR <= '0;
    end else begin
      stateR   <= stateNext;
      grantR   <= grantNext;
      ptrR     <= ptrNext;
      beatCntR <= beatCntNext;
    end
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      fifoValidOut <= 1'b0;
      fifoDataOut  <= '0;
      fifoSrcOut   <= '0;
      fifoLastOut  <= 1'b0;
    end else if (accept) begin
      fifoValidOut <= 1'b1;
      fifoDataOut  <= reqDataIn[grantR*DATA_WIDTH +: DATA_WIDTH];
      fifoSrcOut   <= grantR;
      fifoLastOut  <= beatLast;
    end else if (fifoReadyIn) begin
      fifoValidOut <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: scripted producers, collected FIFO beats
// compared against hand-written expected sequences.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic             clkIn;
  logic             rstNIn;
  logic [NR*DW-1:0] reqDataIn;
  logic [NR-1:0]    reqValidIn;
  logic [NR-1:0]    reqLastIn;
  logic [NR-1:0]    reqReadyOut;
  logic [DW-1:0]    fifoDataOut;
  logic             fifoValidOut;
  logic             fifoReadyIn;
  logic [1:0]       fifoSrcOut;
  logic             fifoLastOut;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(16)) dut (
    .clkIn       (clkIn),
    .rstNIn      (rstNIn),
    .reqDataIn   (reqDataIn),
    .reqValidIn  (reqValidIn),
    .reqLastIn   (reqLastIn),
    .reqReadyOut (reqReadyOut),
    .fifoDataOut (fifoDataOut),
    .fifoValidOut(fifoValidOut),
    .fifoReadyIn (fifoReadyIn),
    .fifoSrcOut  (fifoSrcOut),
    .fifoLastOut (fifoLastOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  int            checks = 0;
  int            errors = 0;
  int            cycleIdx = 0;
  logic [32:0]   prodQ[NR][$];
  logic [63:0]   gotQ[$];
  logic [63:0]   expQ[$];
  int            acceptCycles[$];
  int            expCycles[$];
  logic [NR-1:0] enMask;

  function automatic logic [63:0] mkBeat(input int src, input bit last, input logic [31:0] d);
    return (64'(src) << 33) | (64'(last) << 32) | 64'(d);
  endfunction

  // FIFO side: a beat transfers at the next rising edge when valid and ready are both high.
  always @(negedge clkIn) begin
    if (rstNIn === 1'b1 && fifoValidOut === 1'b1 && fifoReadyIn === 1'b1)
      gotQ.push_back(mkBeat(int'(fifoSrcOut), fifoLastOut, fifoDataOut));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeats(input string tag);
    int n;
    check({tag, " beat count"}, 64'(gotQ.size()), 64'(expQ.size()));
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s beat %0d", tag, i), gotQ[i], expQ[i]);
  endtask

  task automatic stepCycle(input logic rdy);
    bit acc;
    @(posedge clkIn);
    #1;
    fifoReadyIn = rdy;
    for (int i = 0; i < NR; i++) begin
      if (enMask[i] && prodQ[i].size() > 0) begin
        reqValidIn[i]         = 1'b1;
        reqDataIn[i*DW +: DW] = prodQ[i][0][31:0];
        reqLastIn[i]          = prodQ[i][0][32];
      end else begin
        reqValidIn[i]         = 1'b0;
        reqDataIn[i*DW +: DW] = '0;
        reqLastIn[i]          = 1'b0;
      end
    end
    #1;
    acc = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (reqValidIn[i] && reqReadyOut[i]) begin
        void'(prodQ[i].pop_front());
        acc = 1'b1;
      end
    end
    if (acc) acceptCycles.push_back(cycleIdx);
    cycleIdx++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle(1'b1);
  endtask

  task automatic clearBench();
    for (int i = 0; i < NR; i++) prodQ[i].delete();
    gotQ.delete();
    expQ.delete();
    acceptCycles.delete();
    expCycles.delete();
    cycleIdx   = 0;
    enMask     = '1;
    reqValidIn = '0;
    reqLastIn  = '0;
    reqDataIn  = '0;
    fifoReadyIn = 1'b1;
  endtask

  task automatic doReset();
    rstNIn = 1'b0;
    clearBench();
    repeat (2) @(posedge clkIn);
    #3 rstNIn = 1'b1;
  endtask

  initial begin
    rstNIn = 1'b0;
    clearBench();
    #3;
    check("reset fifoValidOut", 64'(fifoValidOut), 64'd0);
    check("reset fifoDataOut", 64'(fifoDataOut), 64'd0);
    check("reset fifoSrcOut", 64'(fifoSrcOut), 64'd0);
    check("reset fifoLastOut", 64'(fifoLastOut), 64'd0);
    check("reset reqReadyOut", 64'(reqReadyOut), 64'd0);
    doReset();

    // Single requester 1, three-beat burst.
    prodQ[1].push_back({1'b0, 32'hA1});
    prodQ[1].push_back({1'b0, 32'hA2});
    prodQ[1].push_back({1'b1, 32'hA3});
    stepCycle(1'b1);
    check("t1 ready in idle", 64'(reqReadyOut), 64'd0);
    stepCycle(1'b1);
    check("t1 ready after arb", 64'(reqReadyOut), 64'b0010);
    runCycles(6);
    expQ = '{mkBeat(1, 0, 32'hA1), mkBeat(1, 0, 32'hA2), mkBeat(1, 1, 32'hA3)};
    checkBeats("t1");
    expCycles = '{1, 2, 3};
    check("t1 accept count", 64'(acceptCycles.size()), 64'(expCycles.size()));
    for (int i = 0; i < 3 && i < acceptCycles.size(); i++)
      check($sformatf("t1 accept cycle %0d", i), 64'(acceptCycles[i]), 64'(expCycles[i]));

    // Four requesters, two-beat bursts, round robin with wrap back to 0.
    doReset();
    for (int r = 0; r < NR; r++) begin
      prodQ[r].push_back({1'b0, 32'h100 + 32'(r * 16)});
      prodQ[r].push_back({1'b1, 32'h101 + 32'(r * 16)});
    end
    prodQ[0].push_back({1'b0, 32'h104});
    prodQ[0].push_back({1'b1, 32'h105});
    runCycles(20);
    expQ = '{mkBeat(0, 0, 32'h100), mkBeat(0, 1, 32'h101),
             mkBeat(1, 0, 32'h110), mkBeat(1, 1, 32'h111),
             mkBeat(2, 0, 32'h120), mkBeat(2, 1, 32'h121),
             mkBeat(3, 0, 32'h130), mkBeat(3, 1, 32'h131),
             mkBeat(0, 0, 32'h104), mkBeat(0, 1, 32'h105)};
    checkBeats("t2");
    expCycles = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14};
    check("t2 accept count", 64'(acceptCycles.size()), 64'(expCycles.size()));
    for (int i = 0; i < 10 && i < acceptCycles.size(); i++)
      check($sformatf("t2 accept cycle %0d", i), 64'(acceptCycles[i]), 64'(expCycles[i]));

    // Requester 2 streams 40 beats without last; forced release lets requester 3 in.
    doReset();
    for (int k = 0; k < 40; k++) prodQ[2].push_back({1'b0, 32'h200 + 32'(k)});
    prodQ[3].push_back({1'b1, 32'h300});
    runCycles(60);
    for (int k = 0; k < 16; k++) expQ.push_back(mkBeat(2, k == 15, 32'h200 + 32'(k)));
    expQ.push_back(mkBeat(3, 1, 32'h300));
    for (int k = 16; k < 32; k++) expQ.push_back(mkBeat(2, k == 31, 32'h200 + 32'(k)));
    for (int k = 32; k < 40; k++) expQ.push_back(mkBeat(2, 0, 32'h200 + 32'(k)));
    checkBeats("t3");

    // Back-pressure: FIFO not ready for 5 cycles mid-burst.
    doReset();
    for (int k = 0; k < 6; k++) prodQ[0].push_back({k == 5, 32'h400 + 32'(k)});
    runCycles(3);
    for (int c = 0; c < 5; c++) begin
      stepCycle(1'b0);
      check($sformatf("t4 stall valid %0d", c), 64'(fifoValidOut), 64'd1);
      check($sformatf("t4 stall data %0d", c), 64'(fifoDataOut), 64'h401);
      check($sformatf("t4 stall ready %0d", c), 64'(reqReadyOut), 64'd0);
    end
    runCycles(10);
    for (int k = 0; k < 6; k++) expQ.push_back(mkBeat(0, k == 5, 32'h400 + 32'(k)));
    checkBeats("t4");

    // Granted requester 1 drops valid for 10 cycles while 0 and 2 wait.
    doReset();
    for (int k = 0; k < 4; k++) prodQ[1].push_back({k == 3, 32'h510 + 32'(k)});
    prodQ[0].push_back({1'b1, 32'h500});
    prodQ[2].push_back({1'b1, 32'h520});
    enMask = 4'b0010;
    stepCycle(1'b1);
    stepCycle(1'b1);
    check("t5 first grant", 64'(reqReadyOut), 64'b0010);
    enMask = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      stepCycle(1'b1);
      check($sformatf("t5 hold ready %0d", c), 64'(reqReadyOut), 64'b0010);
    end
    check("t5 beats during hold", 64'(gotQ.size()), 64'd1);
    enMask = 4'b1111;
    runCycles(15);
    for (int k = 0; k < 4; k++) expQ.push_back(mkBeat(1, k == 3, 32'h510 + 32'(k)));
    expQ.push_back(mkBeat(2, 1, 32'h520));
    expQ.push_back(mkBeat(0, 1, 32'h500));
    checkBeats("t5");

    // Asynchronous reset in the middle of a burst from requester 3.
    doReset();
    for (int k = 0; k < 5; k++) prodQ[3].push_back({k == 4, 32'h630 + 32'(k)});
    runCycles(3);
    check("t6 pre-reset valid", 64'(fifoValidOut), 64'd1);
    check("t6 pre-reset src", 64'(fifoSrcOut), 64'd3);
    #1 rstNIn = 1'b0;
    #1;
    check("t6 reset fifoValidOut", 64'(fifoValidOut), 64'd0);
    check("t6 reset fifoDataOut", 64'(fifoDataOut), 64'd0);
    check("t6 reset fifoSrcOut", 64'(fifoSrcOut), 64'd0);
    check("t6 reset fifoLastOut", 64'(fifoLastOut), 64'd0);
    check("t6 reset reqReadyOut", 64'(reqReadyOut), 64'd0);
    clearBench();
    @(posedge clkIn);
    #3 rstNIn = 1'b1;
    prodQ[0].push_back({1'b1, 32'h600});
    prodQ[2].push_back({1'b1, 32'h620});
    stepCycle(1'b1);
    stepCycle(1'b1);
    check("t6 first grant after reset", 64'(reqReadyOut), 64'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
